// File: rtl/rf_dbg_pkg.sv
// Shared definitions for the register-file debug dump path: FSM states and default sizing.
package rf_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_e;

    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_SEL_W    = 5;
    localparam int DEFAULT_DATA_W   = 32;
    localparam int BYTES_PER_WORD   = DEFAULT_DATA_W / 8;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one captured word and emits it MSB-first as bytes over valid/ready.
// flush drops any partially sent word and beats a same-cycle handshake.
module word_byte_serializer
    import rf_dbg_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              flush,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              last_byte_accepted
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic              valid_q, valid_d;
    logic              last_byte;

    assign last_byte          = (byte_cnt_q == LAST_CNT);
    assign last_byte_accepted = valid_q & out_ready & last_byte & ~flush;
    assign out_data           = shift_q[DATA_W-1 -: 8];
    assign out_valid          = valid_q;

    always_comb begin
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        valid_d    = valid_q;
        if (flush) begin
            shift_d    = '0;
            byte_cnt_d = '0;
            valid_d    = 1'b0;
        end else if (load) begin
            shift_d    = load_data;
            byte_cnt_d = '0;
            valid_d    = 1'b1;
        end else if (valid_q && out_ready) begin
            shift_d    = shift_q << 8;
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
            if (last_byte) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: rtl/rf_dump_reader.sv
// Walks the register file debug port over indices 0..NUM_REGS-1 and streams each
// word out as bytes; each register is snapshotted once, in its LOAD cycle.
module rf_dump_reader
    import rf_dbg_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int SEL_W    = DEFAULT_SEL_W,
    parameter int DATA_W   = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [SEL_W-1:0]  reg_sel,
    input  logic [DATA_W-1:0] reg_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

    dump_state_e      state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] reg_sel_q, reg_sel_d;
    logic             ser_load;
    logic             ser_last_accepted;

    word_byte_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk                (clk),
        .rst                (rst),
        .load               (ser_load),
        .load_data          (reg_data),
        .flush              (abort),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .last_byte_accepted (ser_last_accepted)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ser_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                ser_load = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                if (ser_last_accepted) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + SEL_W'(1);
                        state_d = LOAD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort outranks start in IDLE and any handshake elsewhere
        if (abort) begin
            state_d  = IDLE;
            idx_d    = '0;
            ser_load = 1'b0;
        end
        if (state_d == LOAD) begin
            reg_sel_d = idx_d;
        end else if (state_d == IDLE) begin
            reg_sel_d = '0;
        end else begin
            reg_sel_d = reg_sel_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            reg_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            reg_sel_q <= reg_sel_d;
        end
    end

    assign reg_sel = reg_sel_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule
